// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: fetch FSM encoding,
// opcode/function constants and instruction width.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] FUNC_JR  = 6'd8;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_HALT  = 6'd63;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_jr(input logic [INSTR_W-1:0] word);
        return (word[31:26] == OP_RTYPE) && (word[5:0] == FUNC_JR);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage. Priority: done hold,
// JR, J/JAL, taken branch, sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0]        pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               branch_cond,
    input  logic               jump,
    input  logic               done,
    input  logic [31:0]        rs_data,
    output logic [31:0]        next_pc,
    output logic               misalign
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic        jr;

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jr        = is_jr(instr);

    always_comb begin
        next_pc = pc_plus4;
        if (done) begin
            next_pc = pc;
        end else if (jump && jr) begin
            // Low bits are forced clear; a misaligned target is flagged separately.
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && branch_cond) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

    assign misalign = !done && jump && jr && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch / program counter stage: FETCH -> WAIT -> EXEC -> FETCH,
// with absorbing HALT. Optional misaligned-JR trap under PC_ALIGN_CHECK_EN.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               branch,
    input  logic               branch_cond,
    input  logic               jump,
    input  logic               done,
    input  logic [31:0]        rs_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        link_addr,
    output logic               halted,
    output logic               fault
);

    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_EXEC  = EXEC;
    localparam logic [1:0] S_HALT  = HALT;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic        misalign;
    logic        trap;

    next_pc_calc u_next_pc_calc (
        .pc          (pc),
        .instr       (instr),
        .branch      (branch),
        .branch_cond (branch_cond),
        .jump        (jump),
        .done        (done),
        .rs_data     (rs_data),
        .next_pc     (next_pc),
        .misalign    (misalign)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q;

    assign trap  = misalign;
    assign fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (state == S_EXEC && misalign) begin
            fault_q <= 1'b1;
        end
    end
`else
    // Without the check a misaligned JR simply drops its low bits.
    assign trap  = 1'b0;
    assign fault = misalign & 1'b0;
`endif

    // Handshake: imem_req is a single-cycle strobe in FETCH; memory answers
    // with a single-cycle imem_valid, which is only honoured in WAIT.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign link_addr = pc + 32'd4;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    instr_valid <= 1'b0;
                    if (done || trap) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
